// File: rtl/alu_op_sequencer_if.sv
// Command, response and ALU-facing signals of the ALU op sequencer.
// The sequencer uses the slave modport; the command source / ALU side uses master.
interface alu_op_sequencer_if #(
  parameter int W = 16
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic         cmd_use_acc;
  logic         resp_valid;
  logic         resp_ready;
  logic [W-1:0] resp_data;
  logic         resp_carry;
  logic         resp_zero;
  logic         resp_dbz;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_sel;
  logic [W-1:0] alu_out;
  logic         alu_carry;
  logic [W-1:0] acc;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, resp_ready, alu_out, alu_carry,
    output cmd_ready, resp_valid, resp_data, resp_carry, resp_zero, resp_dbz,
           alu_a, alu_b, alu_sel, acc
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, resp_ready, alu_out, alu_carry,
    input  cmd_ready, resp_valid, resp_data, resp_carry, resp_zero, resp_dbz,
           alu_a, alu_b, alu_sel, acc
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Drives a combinational ALU from registers, captures after SETTLE cycles (response SETTLE+1 after accept, 1 for div-by-zero).
// One op in flight: cmd_ready only in IDLE; the response is held until resp_ready.
module alu_op_sequencer #(
  parameter int W      = 16,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_op_sequencer_if.slave io_bus
);
  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic [3:0]   r_cnt;
  logic [W-1:0] r_alu_a;
  logic [W-1:0] r_alu_b;
  logic [2:0]   r_alu_sel;
  logic [W-1:0] r_data;
  logic         r_carry;
  logic         r_zero;
  logic         r_dbz;
  logic [W-1:0] r_acc;
  logic         w_cmd_rdy;
  logic         w_resp_vld;
  logic         w_capture;
  logic         w_cmd_hs;
  logic         w_dbz_cmd;

  assign w_dbz_cmd = (io_bus.cmd_op == OP_DIV) && (io_bus.cmd_b == '0);
  assign w_cmd_hs  = w_cmd_rdy && io_bus.cmd_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cmd_rdy  = 1'b0;
    w_resp_vld = 1'b0;
    w_capture  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cmd_rdy = 1'b1;
        if (io_bus.cmd_valid) begin
          w_next = w_dbz_cmd ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_cnt == 4'd0) begin
          w_capture = 1'b1;
          w_next    = S_RESP;
        end
      end
      S_RESP: begin
        w_resp_vld = 1'b1;
        if (io_bus.resp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_sel <= '0;
      r_data    <= '0;
      r_carry   <= 1'b0;
      r_zero    <= 1'b0;
      r_dbz     <= 1'b0;
      r_acc     <= '0;
    end else if (w_cmd_hs) begin
      // Divide by zero never reaches the ALU, so operand registers keep their old values.
      if (w_dbz_cmd) begin
        r_data  <= '1;
        r_carry <= 1'b0;
        r_zero  <= 1'b0;
        r_dbz   <= 1'b1;
      end else begin
        r_alu_a   <= io_bus.cmd_use_acc ? r_acc : io_bus.cmd_a;
        r_alu_b   <= io_bus.cmd_b;
        r_alu_sel <= io_bus.cmd_op;
        r_cnt     <= CNT_INIT;
        r_dbz     <= 1'b0;
      end
    end else if (w_capture) begin
      r_data  <= io_bus.alu_out;
      r_carry <= ((r_alu_sel == OP_ADD) || (r_alu_sel == OP_SUB)) && io_bus.alu_carry;
      r_zero  <= (io_bus.alu_out == '0);
      r_acc   <= io_bus.alu_out;
    end else if (r_state == S_ISSUE) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign io_bus.cmd_ready  = w_cmd_rdy;
  assign io_bus.resp_valid = w_resp_vld;
  assign io_bus.resp_data  = r_data;
  assign io_bus.resp_carry = r_carry;
  assign io_bus.resp_zero  = r_zero;
  assign io_bus.resp_dbz   = r_dbz;
  assign io_bus.alu_a      = r_alu_a;
  assign io_bus.alu_b      = r_alu_b;
  assign io_bus.alu_sel    = r_alu_sel;
  assign io_bus.acc        = r_acc;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (SETTLE=1 and SETTLE=4) with a behavioural ALU,
// directed literal checks, random traffic and a per-cycle transaction-level reference model.
module tb_alu_op_sequencer;
  localparam int W = 16;
  int SETL [2] = '{1, 4};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.W(W)) ifc1 ();
  alu_op_sequencer_if #(.W(W)) ifc4 ();

  alu_op_sequencer #(.W(W), .SETTLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .io_bus(ifc1.slave));
  alu_op_sequencer #(.W(W), .SETTLE(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .io_bus(ifc4.slave));

  logic        in_vld [2];
  logic [2:0]  in_op  [2];
  logic [15:0] in_a   [2];
  logic [15:0] in_b   [2];
  logic        in_ua  [2];
  logic        in_rrdy[2];

  logic        o_crdy [2];
  logic        o_rvld [2];
  logic        o_c    [2];
  logic        o_z    [2];
  logic        o_dbz  [2];
  logic [15:0] o_d    [2];
  logic [15:0] o_aa   [2];
  logic [15:0] o_ab   [2];
  logic [2:0]  o_sel  [2];
  logic [15:0] o_acc  [2];

  // Reference ALU: carry forced high on ops where the sequencer must mask it.
  function automatic logic [16:0] alu_f(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] r;
    case (s)
      3'd0:    r = {1'b0, a} + {1'b0, b};
      3'd1:    r = {a < b, a - b};
      3'd2:    r = {1'b1, a * b};
      3'd3:    r = {1'b1, (b == 16'd0) ? 16'd0 : a / b};
      3'd4:    r = {1'b1, a & b};
      3'd5:    r = {1'b1, a | b};
      3'd6:    r = {1'b1, a ^ b};
      default: r = {1'b1, ~a};
    endcase
    return r;
  endfunction

  assign {ifc1.alu_carry, ifc1.alu_out} = alu_f(ifc1.alu_sel, ifc1.alu_a, ifc1.alu_b);
  assign {ifc4.alu_carry, ifc4.alu_out} = alu_f(ifc4.alu_sel, ifc4.alu_a, ifc4.alu_b);

  assign ifc1.cmd_valid = in_vld[0];  assign ifc4.cmd_valid = in_vld[1];
  assign ifc1.cmd_op = in_op[0];      assign ifc4.cmd_op = in_op[1];
  assign ifc1.cmd_a = in_a[0];        assign ifc4.cmd_a = in_a[1];
  assign ifc1.cmd_b = in_b[0];        assign ifc4.cmd_b = in_b[1];
  assign ifc1.cmd_use_acc = in_ua[0]; assign ifc4.cmd_use_acc = in_ua[1];
  assign ifc1.resp_ready = in_rrdy[0]; assign ifc4.resp_ready = in_rrdy[1];

  assign o_crdy[0] = ifc1.cmd_ready;  assign o_crdy[1] = ifc4.cmd_ready;
  assign o_rvld[0] = ifc1.resp_valid; assign o_rvld[1] = ifc4.resp_valid;
  assign o_c[0] = ifc1.resp_carry;    assign o_c[1] = ifc4.resp_carry;
  assign o_z[0] = ifc1.resp_zero;     assign o_z[1] = ifc4.resp_zero;
  assign o_dbz[0] = ifc1.resp_dbz;    assign o_dbz[1] = ifc4.resp_dbz;
  assign o_d[0] = ifc1.resp_data;     assign o_d[1] = ifc4.resp_data;
  assign o_aa[0] = ifc1.alu_a;        assign o_aa[1] = ifc4.alu_a;
  assign o_ab[0] = ifc1.alu_b;        assign o_ab[1] = ifc4.alu_b;
  assign o_sel[0] = ifc1.alu_sel;     assign o_sel[1] = ifc4.alu_sel;
  assign o_acc[0] = ifc1.acc;         assign o_acc[1] = ifc4.acc;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected response {dbz, zero, carry, data} straight from the operation definitions.
  function automatic logic [18:0] ref_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] d;
    logic        c;
    s = '0;
    d = '0;
    c = 1'b0;
    if (op == 3'd3 && b == 16'd0) return {1'b1, 1'b0, 1'b0, 16'hFFFF};
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; d = s[15:0]; c = s[16]; end
      3'd1: begin d = a - b; c = (a < b); end
      3'd2: d = a * b;
      3'd3: d = a / b;
      3'd4: d = a & b;
      3'd5: d = a | b;
      3'd6: d = a ^ b;
      default: d = ~a;
    endcase
    return {1'b0, (d == 16'd0), c, d};
  endfunction

  // Transaction model: pending op, cycles left until its response shows, expected visible state.
  bit          m_pend [2];
  int          m_cnt  [2];
  logic [18:0] m_res  [2];
  logic [15:0] m_acc  [2];
  logic [15:0] m_aa   [2];
  logic [15:0] m_ab   [2];
  logic [2:0]  m_sel  [2];
  logic [15:0] m_opa;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_pend[k] = 1'b0; m_cnt[k] = 0; m_acc[k] = '0;
        m_aa[k] = '0; m_ab[k] = '0; m_sel[k] = '0;
      end else if (m_pend[k] && m_cnt[k] == 0) begin
        if (in_rrdy[k]) m_pend[k] = 1'b0;
      end else if (m_pend[k]) begin
        m_cnt[k]--;
        if (m_cnt[k] == 0) m_acc[k] = m_res[k][15:0];
      end else if (in_vld[k]) begin
        m_opa = in_ua[k] ? m_acc[k] : in_a[k];
        m_res[k] = ref_f(in_op[k], m_opa, in_b[k]);
        m_pend[k] = 1'b1;
        if (m_res[k][18]) begin
          m_cnt[k] = 0;
        end else begin
          m_cnt[k] = SETL[k];
          m_aa[k] = m_opa; m_ab[k] = in_b[k]; m_sel[k] = in_op[k];
        end
      end
      chk($sformatf("cmd_ready[%0d]", k), 32'(o_crdy[k]), 32'(!m_pend[k]));
      chk($sformatf("resp_valid[%0d]", k), 32'(o_rvld[k]), 32'(m_pend[k] && m_cnt[k] == 0));
      chk($sformatf("acc[%0d]", k), 32'(o_acc[k]), 32'(m_acc[k]));
      chk($sformatf("alu_a[%0d]", k), 32'(o_aa[k]), 32'(m_aa[k]));
      chk($sformatf("alu_b[%0d]", k), 32'(o_ab[k]), 32'(m_ab[k]));
      chk($sformatf("alu_sel[%0d]", k), 32'(o_sel[k]), 32'(m_sel[k]));
      if (m_pend[k] && m_cnt[k] == 0) begin
        chk($sformatf("resp_data[%0d]", k), 32'(o_d[k]), 32'(m_res[k][15:0]));
        chk($sformatf("resp_carry[%0d]", k), 32'(o_c[k]), 32'(m_res[k][16]));
        chk($sformatf("resp_zero[%0d]", k), 32'(o_z[k]), 32'(m_res[k][17]));
        chk($sformatf("resp_dbz[%0d]", k), 32'(o_dbz[k]), 32'(m_res[k][18]));
      end
    end
  end

  // One full transaction; lat counts clock edges from the accept edge until resp_valid is seen.
  task automatic send(input int k, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic ua, input int lo, input bit early,
                      output logic [15:0] d, output logic c, output logic z, output logic dz,
                      output int lat);
    int t;
    @(negedge clk);
    t = 0;
    while (!o_crdy[k] && t < 100) begin @(negedge clk); t++; end
    chk("accept_timeout", 32'(t >= 100), 32'd0);
    #1;
    in_vld[k] = 1'b1; in_op[k] = op; in_a[k] = a; in_b[k] = b; in_ua[k] = ua;
    in_rrdy[k] = early;
    @(negedge clk); #1;
    // Junk command fields while busy must be ignored.
    in_op[k] = 3'($urandom); in_a[k] = 16'($urandom); in_b[k] = 16'($urandom); in_ua[k] = 1'($urandom);
    in_vld[k] = early ? 1'b0 : 1'($urandom_range(0, 1));
    lat = 1;
    while (!o_rvld[k] && lat < 50) begin @(negedge clk); lat++; end
    chk("resp_timeout", 32'(lat >= 50), 32'd0);
    d = o_d[k]; c = o_c[k]; z = o_z[k]; dz = o_dbz[k];
    if (!early) begin
      for (int i = 0; i < lo; i++) begin
        @(negedge clk);
        chk("hold_cmd_ready", 32'(o_crdy[k]), 32'd0);
        chk("hold_resp_valid", 32'(o_rvld[k]), 32'd1);
        chk("hold_resp_data", 32'(o_d[k]), 32'(d));
      end
    end
    #1;
    in_rrdy[k] = 1'b1; in_vld[k] = 1'b0;
    @(negedge clk); #1;
    in_rrdy[k] = 1'b0;
  endtask

  task automatic rand_stream(input int k, input int n);
    logic [15:0] d;
    logic        c, z, dz;
    int          lat;
    logic [2:0]  op;
    logic [15:0] b;
    bit          early;
    for (int i = 0; i < n; i++) begin
      op = 3'($urandom_range(0, 7));
      b = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom);
      early = ($urandom_range(0, 3) == 0);
      send(k, op, 16'($urandom), b, 1'($urandom), early ? 0 : $urandom_range(0, 3), early,
           d, c, z, dz, lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] d;
    logic        c, z, dz;
    int          lat;
    for (int k = 0; k < 2; k++) begin
      in_vld[k] = 1'b0; in_op[k] = '0; in_a[k] = '0; in_b[k] = '0; in_ua[k] = 1'b0; in_rrdy[k] = 1'b0;
    end
    #2;
    chk("rst_cmd_ready", 32'(o_crdy[0]), 32'd1);
    chk("rst_resp_valid", 32'(o_rvld[0]), 32'd0);
    chk("rst_acc", 32'(o_acc[1]), 32'd0);
    chk("rst_alu_sel", 32'(o_sel[0]), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    send(0, 3'd0, 16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, d, c, z, dz, lat);
    chk("add_lat", 32'(lat), 32'd2);
    chk("add_data", 32'(d), 32'h0000);
    chk("add_carry", 32'(c), 32'd1);
    chk("add_zero", 32'(z), 32'd1);
    send(0, 3'd1, 16'h0003, 16'h0005, 1'b0, 0, 1'b0, d, c, z, dz, lat);
    chk("sub_data", 32'(d), 32'hFFFE);
    chk("sub_borrow", 32'(c), 32'd1);
    chk("sub_acc", 32'(o_acc[0]), 32'hFFFE);
    send(0, 3'd3, 16'h0010, 16'h0000, 1'b0, 0, 1'b0, d, c, z, dz, lat);
    chk("dbz_lat", 32'(lat), 32'd1);
    chk("dbz_data", 32'(d), 32'hFFFF);
    chk("dbz_flag", 32'(dz), 32'd1);
    chk("dbz_acc", 32'(o_acc[0]), 32'hFFFE);
    send(0, 3'd0, 16'd5, 16'd7, 1'b0, 0, 1'b0, d, c, z, dz, lat);
    chk("chain_add", 32'(d), 32'h000C);
    send(0, 3'd2, 16'hBEEF, 16'd3, 1'b1, 0, 1'b0, d, c, z, dz, lat);
    chk("chain_mul", 32'(d), 32'h0024);
    chk("chain_acc", 32'(o_acc[0]), 32'h0024);
    send(0, 3'd4, 16'hF0F0, 16'hFF00, 1'b0, 0, 1'b0, d, c, z, dz, lat);
    chk("and_data", 32'(d), 32'hF000);
    chk("and_carry", 32'(c), 32'd0);
    send(0, 3'd6, 16'h1234, 16'h1234, 1'b0, 0, 1'b0, d, c, z, dz, lat);
    chk("xor_zero", 32'(z), 32'd1);
    chk("xor_carry", 32'(c), 32'd0);
    send(0, 3'd0, 16'd1, 16'd2, 1'b0, 10, 1'b0, d, c, z, dz, lat);
    chk("hold_data_final", 32'(d), 32'h0003);
    send(0, 3'd5, 16'h0F00, 16'h00F0, 1'b0, 0, 1'b0, d, c, z, dz, lat);
    chk("after_hold_lat", 32'(lat), 32'd2);
    chk("after_hold_or", 32'(d), 32'h0FF0);
    send(1, 3'd0, 16'd100, 16'd23, 1'b0, 0, 1'b0, d, c, z, dz, lat);
    chk("settle4_lat", 32'(lat), 32'd5);
    chk("settle4_data", 32'(d), 32'h007B);

    fork
      rand_stream(0, 200);
      rand_stream(1, 60);
    join

    // Abort an op on the SETTLE=4 instance while it is still in ISSUE.
    @(negedge clk); #1;
    in_vld[1] = 1'b1; in_op[1] = 3'd0; in_a[1] = 16'd3; in_b[1] = 16'd4; in_ua[1] = 1'b0;
    @(negedge clk); #1;
    in_vld[1] = 1'b0;
    @(negedge clk); #1;
    chk("pre_rst_alu_a", 32'(o_aa[1]), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("arst_cmd_ready", 32'(o_crdy[1]), 32'd1);
    chk("arst_resp_valid", 32'(o_rvld[1]), 32'd0);
    chk("arst_acc", 32'(o_acc[1]), 32'd0);
    chk("arst_alu_a", 32'(o_aa[1]), 32'd0);
    chk("arst_acc0", 32'(o_acc[0]), 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_rst_no_resp", 32'(o_rvld[1]), 32'd0);
    send(1, 3'd7, 16'h00FF, 16'd0, 1'b0, 0, 1'b0, d, c, z, dz, lat);
    chk("post_rst_not", 32'(d), 32'hFF00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
